magic_cfg_tx: RTL and testbench

Serial transmitter that mirrors magic-menu configuration writes out to the board MCU so settings can be persisted and restored. It snoops CPU writes to the magic config port (I/O `xxFF` while the magic ROM is mapped) and queues each `{register, value}` pair in a small FIFO. It then shifts each pair out as a 16-bit SPI-mode-0 frame on a dedicated MCU link. It sits beside the magic/config block on the same `cpu_bus` and never drives the data bus.

---
 rtl/magic_cfg_tx_if.sv | 14 +
 rtl/magic_cfg_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_magic_cfg_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magic_cfg_tx_if.sv
// cpu_bus: CPU bus signals seen by blocks that sit on the Z80 side.
//   ioreq  - I/O request strobe
//   wr     - write strobe
//   a      - 16-bit address
//   d      - 8-bit data as driven by the CPU on writes
// The snoop modport is read-only: snooping blocks never drive the bus.
interface cpu_bus;
  logic        ioreq;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  d;

  modport snoop (input ioreq, input wr, input a, input d);
endinterface

// File: rtl/magic_cfg_tx.sv
// magic_cfg_tx: mirrors magic-menu configuration writes to the board MCU.
// Writes to I/O port xxFF while the magic ROM is mapped are captured as
// {register, value}, queued in a small FIFO and sent as 16-bit SPI mode-0
// frames (MSB first) on a dedicated link.
//
// Ports:
//   clk28      in   28 MHz system clock
//   rst_n      in   asynchronous active-low reset
//   bus        in   cpu_bus snoop (ioreq, wr, a, d)
//   magic_map  in   magic ROM mapped; qualifies config writes
//   tx_en      in   link enable; 0 holds off new frames, queuing continues
//   mcu_ss_n   out  frame select, active low
//   mcu_sck    out  serial clock, idle low
//   mcu_mosi   out  serial data, MSB first
//   busy       out  FIFO non-empty or frame in progress
//   overflow   out  sticky: a write was dropped on a full FIFO
module magic_cfg_tx #(
  parameter int FIFO_DEPTH = 4,  // power of two, >= 2
  parameter int SCK_DIV    = 8   // even, >= 4
) (
  input  logic  clk28,
  input  logic  rst_n,
  cpu_bus.snoop bus,
  input  logic  magic_map,
  input  logic  tx_en,
  output logic  mcu_ss_n,
  output logic  mcu_sck,
  output logic  mcu_mosi,
  output logic  busy,
  output logic  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(SCK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // ---------------------------------------------------------------------
  // Write snoop. An OUT keeps the strobe high for many clk28 cycles, so
  // only its rising edge captures.
  // ---------------------------------------------------------------------
  logic strobe;
  logic s_q;
  logic capture;
  logic cap_zero;
  logic push_req;
  logic push;
  logic pop;

  assign strobe   = magic_map & bus.ioreq & bus.wr & (bus.a[7:0] == 8'hFF);
  assign capture  = strobe & ~s_q;
  assign cap_zero = capture & (bus.a[15:8] == 8'h00);
  assign push_req = capture & ~cap_zero;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_q;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  // Pop is resolved first, so a full FIFO being popped this cycle still
  // has room for the incoming entry.
  assign push       = push_req & (~fifo_full | pop);

  always_ff @(posedge clk28) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.a[15:8], bus.d};
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      s_q <= strobe;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (cap_zero) begin
        overflow_q <= 1'b0;
      end else if (push_req && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM. div counts clk28 cycles inside each SCK_DIV-long slot
  // (setup, each bit period, hold, gap).
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      sh_q, sh_d;
  logic             ss_n_q, ss_n_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             start_ok;
  logic             div_end;

  assign start_ok = ~fifo_empty & tx_en;
  assign div_end  = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_SETUP;
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          div_d   = '0;
        end
      end
      ST_SETUP: begin
        if (div_end) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = 4'd15;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          // End of a bit period: sck falls and the next bit is presented.
          div_d = '0;
          sh_d  = {sh_q[14:0], 1'b0};
          if (bit_q == 4'd0) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (div_end) begin
          state_d = ST_GAP;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_end) begin
          // Chain straight into the next frame so the ss_n high time
          // between back-to-back frames is exactly one slot.
          div_d = '0;
          if (start_ok) begin
            state_d = ST_SETUP;
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase

    // Link pins are registered from the next state for glitch-free outputs.
    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    sck_d  = (state_d == ST_SHIFT) && (div_d >= DIV_HALF);
    mosi_d = ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) ? sh_d[15] : 1'b0;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ss_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ss_n_q  <= ss_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign mcu_ss_n = ss_n_q;
  assign mcu_sck  = sck_q;
  assign mcu_mosi = mosi_q;
  assign busy     = (cnt_q != '0) || (state_q != ST_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_magic_cfg_tx.sv
// Testbench for magic_cfg_tx: drives Z80-style OUT cycles on cpu_bus,
// decodes the SPI link with an independent monitor and compares against
// expectations from the write rules and frame timing.
module tb_magic_cfg_tx;

  localparam int D     = 8;
  localparam int DEPTH = 4;

  logic clk28     = 1'b0;
  logic rst_n     = 1'b0;
  logic magic_map = 1'b1;
  logic tx_en     = 1'b1;
  logic mcu_ss_n;
  logic mcu_sck;
  logic mcu_mosi;
  logic busy;
  logic overflow;

  cpu_bus bus_if();

  magic_cfg_tx #(.FIFO_DEPTH(DEPTH), .SCK_DIV(D)) dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .magic_map (magic_map),
    .tx_en     (tx_en),
    .mcu_ss_n  (mcu_ss_n),
    .mcu_sck   (mcu_sck),
    .mcu_mosi  (mcu_mosi),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk28 = ~clk28;

  int cyc = 0;
  always @(posedge clk28) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- link monitor ----------------
  typedef struct {
    logic [15:0] data;
    int          nbits;
    int          start;
    int          len;
    int          gap;
  } frame_t;

  frame_t      rx_q[$];
  logic        prev_ss   = 1'b1;
  logic        prev_sck  = 1'b0;
  logic        prev_mosi = 1'b0;
  logic [15:0] cur_data  = '0;
  int          cur_bits  = 0;
  int          cur_start = 0;
  int          cur_gap   = 0;
  int          last_rise = -100000;
  int          sck_outside = 0;
  int          mosi_glitch = 0;
  bit          busy_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk28);
      if (busy === 1'b1) busy_seen = 1'b1;
      if (prev_ss && !mcu_ss_n) begin
        cur_start = cyc;
        cur_gap   = cyc - last_rise;
        cur_bits  = 0;
        cur_data  = '0;
      end
      if (!mcu_ss_n && mcu_sck && !prev_sck) begin
        cur_data = {cur_data[14:0], mcu_mosi};
        cur_bits++;
      end
      if (mcu_ss_n && mcu_sck) sck_outside++;
      if (mcu_sck && prev_sck && (mcu_mosi !== prev_mosi)) mosi_glitch++;
      if (!prev_ss && mcu_ss_n) begin
        frame_t f;
        f.data  = cur_data;
        f.nbits = cur_bits;
        f.start = cur_start;
        f.len   = cyc - cur_start;
        f.gap   = cur_gap;
        rx_q.push_back(f);
        last_rise = cyc;
        $display("[TB] frame %h bits %0d len %0d start %0d gap %0d",
                 f.data, f.nbits, f.len, f.start, f.gap);
      end
      prev_ss   = mcu_ss_n;
      prev_sck  = mcu_sck;
      prev_mosi = mcu_mosi;
    end
  end

  // ---------------- reference model ----------------
  // Each accepted entry leaves the queue when its frame starts; a frame
  // starts one cycle after capture or 19*D cycles after the previous start,
  // whichever is later (tx_en held high).
  logic [15:0] exp_data[$];
  int          exp_start[$];
  int          last_start = -1000000;
  bit          exp_ovf    = 1'b0;

  function automatic void model_reset();
    exp_data.delete();
    exp_start.delete();
    last_start = -1000000;
  endfunction

  function automatic void model_out(int c, logic [7:0] r, logic [7:0] v);
    int pending;
    int s;
    if (r == 8'h00) begin
      exp_ovf = 1'b0;
    end else begin
      pending = 0;
      foreach (exp_start[i]) if (exp_start[i] > c) pending++;
      if (pending >= DEPTH) begin
        exp_ovf = 1'b1;
      end else begin
        s = (c + 1 > last_start + 19 * D) ? c + 1 : last_start + 19 * D;
        last_start = s;
        exp_data.push_back({r, v});
        exp_start.push_back(s);
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic do_out(input logic [7:0] r, input logic [7:0] v, input logic [7:0] lo,
                        input bit mm, input int hold, input int idle);
    @(negedge clk28);
    bus_if.a     = {r, lo};
    bus_if.d     = v;
    magic_map    = mm;
    bus_if.ioreq = 1'b1;
    bus_if.wr    = 1'b1;
    if (mm && lo == 8'hFF) model_out(cyc + 1, r, v);
    repeat (hold) @(negedge clk28);
    bus_if.ioreq = 1'b0;
    bus_if.wr    = 1'b0;
    magic_map    = 1'b1;
    repeat (idle) @(negedge clk28);
  endtask

  task automatic wait_idle(output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    @(negedge clk28);
    while (busy !== 1'b0) begin
      @(negedge clk28);
      n++;
      if (n > 20000) begin
        timed_out = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk28);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk28);
    n_tests++; if (mcu_ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", mcu_ss_n); end
    n_tests++; if (mcu_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", mcu_sck); end
    n_tests++; if (mcu_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mcu_mosi); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk28);
    n_tests++; if (mcu_ss_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: ss_n %b busy %b want 1 0", mcu_ss_n, busy);
    end
  endtask

  task automatic test_single();
    bit to;
    int c;
    rx_q.delete();
    sck_outside = 0;
    mosi_glitch = 0;
    model_reset();
    @(negedge clk28);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_pre: got %b want 0", busy); end
    bus_if.a = 16'h03FF; bus_if.d = 8'h5A; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    c = cyc + 1;
    @(posedge clk28); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    repeat (23) @(negedge clk28);
    bus_if.ioreq = 1'b0; bus_if.wr = 1'b0;
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL single_timeout: busy stuck at 1"); end
    n_tests++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d frames want 1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      n_tests++; if (rx_q[0].data !== 16'h035A) begin n_fail++; $display("FAIL single_data: got %h want 035a", rx_q[0].data); end
      n_tests++; if (rx_q[0].nbits != 16) begin n_fail++; $display("FAIL single_sck_edges: got %0d want 16", rx_q[0].nbits); end
      n_tests++; if (rx_q[0].len != 18 * D) begin n_fail++; $display("FAIL single_len: got %0d want %0d", rx_q[0].len, 18 * D); end
      n_tests++; if (rx_q[0].start != c + 1) begin n_fail++; $display("FAIL single_start: got %0d want %0d", rx_q[0].start, c + 1); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_tests++; if (sck_outside != 0) begin n_fail++; $display("FAIL single_sck_idle: got %0d high cycles want 0", sck_outside); end
    n_tests++; if (mosi_glitch != 0) begin n_fail++; $display("FAIL single_mosi_stable: got %0d changes want 0", mosi_glitch); end
  endtask

  task automatic test_qualification();
    rx_q.delete();
    busy_seen = 1'b0;
    do_out(8'h03, 8'h77, 8'hFF, 1'b0, 24, 4);
    do_out(8'h03, 8'h77, 8'hFE, 1'b1, 24, 300);
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL qual_frames: got %0d want 0", rx_q.size()); end
    n_tests++; if (busy_seen) begin n_fail++; $display("FAIL qual_busy: got busy high want 0"); end
  endtask

  task automatic test_long_strobe();
    bit to;
    rx_q.delete();
    do_out(8'h21, 8'hC3, 8'hFF, 1'b1, 30, 2);
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL long_timeout: busy stuck at 1"); end
    n_tests++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL long_count: got %0d want 1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      n_tests++; if (rx_q[0].data !== 16'h21C3) begin n_fail++; $display("FAIL long_data: got %h want 21c3", rx_q[0].data); end
    end
  endtask

  task automatic test_overflow();
    bit to;
    logic [7:0] vals[6];
    rx_q.delete();
    model_reset();
    for (int i = 0; i < 6; i++) begin
      vals[i] = 8'($urandom);
      do_out(8'(i + 1), vals[i], 8'hFF, 1'b1, 12, 11);
      if (i == 4) begin
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_after5: got %b want 0", overflow); end
      end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after6: got %b want 1", overflow); end
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL ovf_timeout: busy stuck at 1"); end
    n_tests++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_tests++;
      if (rx_q[i].data !== {8'(i + 1), vals[i]}) begin
        n_fail++; $display("FAIL ovf_data[%0d]: got %h want %h", i, rx_q[i].data, {8'(i + 1), vals[i]});
      end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    rx_q.delete();
    busy_seen = 1'b0;
    do_out(8'h00, 8'h99, 8'hFF, 1'b1, 24, 300);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL ovf_clear_frames: got %0d want 0", rx_q.size()); end
    n_tests++; if (busy_seen) begin n_fail++; $display("FAIL ovf_clear_busy: got busy high want 0"); end
  endtask

  task automatic test_tx_en_gating();
    bit to;
    rx_q.delete();
    tx_en = 1'b0;
    do_out(8'h41, 8'h10, 8'hFF, 1'b1, 24, 4);
    do_out(8'h42, 8'h20, 8'hFF, 1'b1, 24, 200);
    n_tests++; if (rx_q.size() != 0 || mcu_ss_n !== 1'b1) begin
      n_fail++; $display("FAIL gate_hold: got %0d frames ss_n %b want 0 frames ss_n 1", rx_q.size(), mcu_ss_n);
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gate_busy: got %b want 1", busy); end
    @(negedge clk28);
    tx_en = 1'b1;
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL gate_timeout: busy stuck at 1"); end
    n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL gate_count: got %0d want 2", rx_q.size()); end
    if (rx_q.size() >= 2) begin
      n_tests++; if (rx_q[0].data !== 16'h4110) begin n_fail++; $display("FAIL gate_data0: got %h want 4110", rx_q[0].data); end
      n_tests++; if (rx_q[1].data !== 16'h4220) begin n_fail++; $display("FAIL gate_data1: got %h want 4220", rx_q[1].data); end
      n_tests++; if (rx_q[1].gap != D) begin n_fail++; $display("FAIL gate_gap: got %0d want %0d", rx_q[1].gap, D); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [7:0] r, v, lo;
    bit mm;
    rx_q.delete();
    model_reset();
    sck_outside = 0;
    mosi_glitch = 0;
    for (int i = 0; i < 24; i++) begin
      r  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      v  = 8'($urandom);
      lo = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'hFF;
      mm = ($urandom_range(0, 7) != 0);
      do_out(r, v, lo, mm, $urandom_range(1, 30), $urandom_range(1, 150));
      n_tests++;
      if (overflow !== exp_ovf) begin
        n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, overflow, exp_ovf);
      end
    end
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rand_timeout: busy stuck at 1"); end
    n_tests++;
    if (rx_q.size() != exp_data.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_data.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_data.size(); i++) begin
      n_tests++;
      if (rx_q[i].data !== exp_data[i] || rx_q[i].start != exp_start[i] || rx_q[i].len != 18 * D) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got %h@%0d len %0d want %h@%0d len %0d", i,
                 rx_q[i].data, rx_q[i].start, rx_q[i].len, exp_data[i], exp_start[i], 18 * D);
      end
    end
    n_tests++; if (sck_outside != 0 || mosi_glitch != 0) begin
      n_fail++; $display("FAIL rand_link: sck_outside %0d mosi_glitch %0d want 0 0", sck_outside, mosi_glitch);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    cur_bits = 0;
    do_out(8'h11, 8'hA5, 8'hFF, 1'b1, 4, 30);
    do_out(8'h12, 8'h5A, 8'hFF, 1'b1, 4, 4);
    n = 0;
    while (cur_bits < 9 && n < 3000) begin
      @(negedge clk28);
      n++;
    end
    n_tests++; if (cur_bits < 9) begin n_fail++; $display("FAIL rst_reach_bit7: got %0d edges want 9", cur_bits); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mcu_ss_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ss_n: got %b want 1", mcu_ss_n); end
    n_tests++; if (mcu_sck !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sck: got %b want 0", mcu_sck); end
    n_tests++; if (mcu_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mosi: got %b want 0", mcu_mosi); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk28);
    rx_q.delete();
    busy_seen = 1'b0;
    repeat (400) @(negedge clk28);
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rst_after_frames: got %0d want 0", rx_q.size()); end
    n_tests++; if (busy_seen) begin n_fail++; $display("FAIL rst_after_busy: got busy high want 0"); end
  endtask

  initial begin
    bus_if.ioreq = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.a     = 16'h0000;
    bus_if.d     = 8'h00;
    test_reset();
    test_single();
    test_qualification();
    test_long_strobe();
    test_overflow();
    test_tx_en_gating();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
